ps2_host_cmd: RTL and testbench

//  Host-to-device command sequencer for the PS/2 keyboard port. Accepts one command byte
//  (e.g. 8'hED LED set, 8'hFF reset), inhibits the bus, transmits the host-to-device frame,

---
 rtl/ps2_host_cmd.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_host_cmd.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_cmd.sv
// PS/2 host-to-device command sequencer: inhibit, send frame, check line-ack,
// receive the response byte and resend the command on 8'hFE.
module ps2_host_cmd #(
    parameter int          INHIBIT = 400,
    parameter logic [15:0] TIMEOUT = 16'hFFFF,
    parameter int          RETRIES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic [1:0] ps2,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    input  logic [7:0] cmd,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       busy,
    output logic [7:0] resp,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_TX, S_LACK, S_RX, S_ERROR
    } state_t;

    // Inhibit loads INHIBIT-2 so ps2c_oe is held for exactly INHIBIT ce ticks.
    localparam logic [15:0] INH_LOAD  = 16'(INHIBIT - 2);
    localparam logic [15:0] TMO_LOAD  = TIMEOUT - 16'd1;
    localparam logic [3:0]  RETRY_MAX = 4'(RETRIES);

    state_t      state_q, state_d;
    logic [7:0]  flt_q, flt_d;
    logic        lvl_q, lvl_d;
    logic        fall_q, fall_d;
    logic        dat_q, dat_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        par_q, par_d;
    logic [3:0]  retry_q, retry_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic        rpar_q, rpar_d;
    logic [15:0] tmr_q, tmr_d;
    logic        ps2c_oe_q, ps2c_oe_d;
    logic        ps2d_oe_q, ps2d_oe_d;
    logic [7:0]  resp_q, resp_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        timed;

    assign timed = (state_q == S_START) || (state_q == S_TX) ||
                   (state_q == S_LACK)  || (state_q == S_RX);

    always_comb begin
        state_d   = state_q;
        flt_d     = flt_q;
        lvl_d     = lvl_q;
        fall_d    = fall_q;
        dat_d     = dat_q;
        cmd_d     = cmd_q;
        par_d     = par_q;
        retry_d   = retry_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        rpar_d    = rpar_q;
        tmr_d     = tmr_q;
        ps2c_oe_d = ps2c_oe_q;
        ps2d_oe_d = ps2d_oe_q;
        resp_d    = resp_q;
        done_d    = done_q;
        err_d     = err_q;
        if (ce) begin
            flt_d  = {flt_q[6:0], ps2[0]};
            dat_d  = ps2[1];
            fall_d = 1'b0;
            done_d = 1'b0;
            err_d  = 1'b0;
            if (flt_q == 8'hFF) begin
                lvl_d = 1'b1;
            end else if (flt_q == 8'h00) begin
                lvl_d  = 1'b0;
                fall_d = lvl_q;
            end
            if (timed) tmr_d = fall_q ? TMO_LOAD : tmr_q - 16'd1;
            case (state_q)
                S_IDLE: if (cmd_valid) begin
                    cmd_d     = cmd;
                    par_d     = ~^cmd;
                    retry_d   = 4'd0;
                    ps2c_oe_d = 1'b1;
                    tmr_d     = INH_LOAD;
                    state_d   = S_INHIBIT;
                end
                S_INHIBIT: if (tmr_q == 16'd0) begin
                    ps2d_oe_d = 1'b1;
                    tmr_d     = TMO_LOAD;
                    state_d   = S_START;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
                S_START: begin
                    ps2c_oe_d = 1'b0;
                    ps2d_oe_d = 1'b1;
                    cnt_d     = 4'd0;
                    tmr_d     = TMO_LOAD;
                    state_d   = S_TX;
                end
                S_TX: if (fall_q) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q < 4'd8) begin
                        ps2d_oe_d = ~cmd_q[cnt_q[2:0]];
                    end else if (cnt_q == 4'd8) begin
                        ps2d_oe_d = ~par_q;
                    end else begin
                        ps2d_oe_d = 1'b0;
                        cnt_d     = 4'd0;
                        state_d   = S_LACK;
                    end
                end
                S_LACK: if (fall_q) begin
                    cnt_d   = 4'd0;
                    state_d = dat_q ? S_ERROR : S_RX;
                end
                S_RX: if (fall_q) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd0) begin
                        if (dat_q) state_d = S_ERROR;
                    end else if (cnt_q <= 4'd8) begin
                        sh_d = {dat_q, sh_q[7:1]};
                    end else if (cnt_q == 4'd9) begin
                        rpar_d = dat_q;
                    end else if (!dat_q || !(^{sh_q, rpar_q})) begin
                        state_d = S_ERROR;
                    end else begin
                        resp_d = sh_q;
                        if (sh_q != 8'hFE) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else if (retry_q < RETRY_MAX) begin
                            retry_d   = retry_q + 4'd1;
                            ps2c_oe_d = 1'b1;
                            tmr_d     = INH_LOAD;
                            state_d   = S_INHIBIT;
                        end else begin
                            state_d = S_ERROR;
                        end
                    end
                end
                S_ERROR: begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
            if (timed && !fall_q && tmr_q == 16'd0) state_d = S_ERROR;
            if (state_d == S_ERROR) begin
                ps2c_oe_d = 1'b0;
                ps2d_oe_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            flt_q     <= 8'hFF;
            lvl_q     <= 1'b1;
            fall_q    <= 1'b0;
            dat_q     <= 1'b1;
            cmd_q     <= 8'h00;
            par_q     <= 1'b0;
            retry_q   <= 4'd0;
            cnt_q     <= 4'd0;
            sh_q      <= 8'h00;
            rpar_q    <= 1'b0;
            tmr_q     <= 16'd0;
            ps2c_oe_q <= 1'b0;
            ps2d_oe_q <= 1'b0;
            resp_q    <= 8'h00;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            flt_q     <= flt_d;
            lvl_q     <= lvl_d;
            fall_q    <= fall_d;
            dat_q     <= dat_d;
            cmd_q     <= cmd_d;
            par_q     <= par_d;
            retry_q   <= retry_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            rpar_q    <= rpar_d;
            tmr_q     <= tmr_d;
            ps2c_oe_q <= ps2c_oe_d;
            ps2d_oe_q <= ps2d_oe_d;
            resp_q    <= resp_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ps2c_oe   = ps2c_oe_q;
    assign ps2d_oe   = ps2d_oe_q;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign resp      = resp_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ps2_host_cmd.sv
// Bench for ps2_host_cmd: a PS/2 device model on the open-drain bus plus a
// transaction-level outcome model and a per-ce-tick invariant monitor.
module tb_ps2_host_cmd;

    localparam int          INH = 40;
    localparam logic [15:0] TMO = 16'd600;
    localparam int          RET = 2;
    localparam int          H   = 15;
    localparam int K_OK = 0, K_NACK = 1, K_BADPAR = 2, K_SILENT = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ce = 1'b0;
    wire  [1:0] ps2;
    logic       ps2c_oe, ps2d_oe;
    logic [7:0] cmd = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready, busy;
    logic [7:0] resp;
    logic       done, err;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;

    assign ps2[0] = ~ps2c_oe & ~dev_c_low;
    assign ps2[1] = ~ps2d_oe & ~dev_d_low;

    ps2_host_cmd #(.INHIBIT(INH), .TIMEOUT(TMO), .RETRIES(RET)) dut (
        .clock(clock), .reset(reset), .ce(ce), .ps2(ps2),
        .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .busy(busy), .resp(resp), .done(done), .err(err)
    );

    always #5 clock = ~clock;
    always @(negedge clock) ce = ($urandom_range(0, 3) != 0);

    int         tests = 0, fails = 0;
    int         done_n = 0, err_n = 0, inh_run = 0, inh_dlow = 0, inh_runs = 0;
    logic [7:0] resp_exp = 8'h00;
    logic [9:0] last_fr = 10'h000;
    int         plan_k[3];
    logic [7:0] plan_b[3];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        do @(posedge clock); while (!ce);
        #1;
    endtask

    // Invariants that hold on every ce tick, plus pulse and inhibit bookkeeping.
    initial forever begin
        tick();
        check("ready_vs_busy", cmd_ready, !busy);
        check("done_and_err", done && err, 0);
        if (!busy) begin
            check("idle_oe", {ps2c_oe, ps2d_oe}, 0);
            check("idle_resp", resp, resp_exp);
        end
        if (done) done_n++;
        if (err) err_n++;
        if (ps2c_oe) begin
            inh_run++;
            if (ps2d_oe) inh_dlow++;
        end else if (inh_run > 0) begin
            check("inhibit_len", inh_run, INH);
            check("inhibit_data_last", inh_dlow, 1);
            check("start_bit", ps2d_oe, 1);
            inh_runs++;
            inh_run  = 0;
            inh_dlow = 0;
        end
    end

    task automatic wait_start(output bit ok);
        int k = 0;
        while (!(ps2[0] && !ps2[1]) && k < INH + 100) begin
            tick();
            k++;
        end
        ok = (k < INH + 100);
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL start_seen: no start bit after %0d ticks", k);
        end
    endtask

    task automatic clk_pulse();
        dev_c_low = 1'b1;
        repeat (H) tick();
        dev_c_low = 1'b0;
        repeat (H) tick();
    endtask

    // One device-side exchange: clock in the host frame, ack, reply.
    task automatic serve(input logic [7:0] c, input int kind, input logic [7:0] rb);
        bit ok;
        logic [9:0]  fr;
        logic [10:0] bits;
        wait_start(ok);
        if (!ok || kind == K_SILENT) return;
        repeat (12) tick();
        cmd_valid = 1'b1;
        cmd = ~c;
        for (int i = 0; i < 10; i++) begin
            clk_pulse();
            fr[i] = ps2[1];
        end
        cmd_valid = 1'b0;
        last_fr = fr;
        check("tx_frame", fr, {1'b1, ~^c, c});
        dev_d_low = (kind != K_NACK);
        clk_pulse();
        dev_d_low = 1'b0;
        if (kind == K_NACK) return;
        repeat (10) tick();
        bits = {1'b1, (kind == K_BADPAR) ? ^rb : ~^rb, rb, 1'b0};
        for (int i = 0; i < 11; i++) begin
            dev_d_low = !bits[i];
            repeat (H) tick();
            dev_c_low = 1'b1;
            repeat (H) tick();
            dev_c_low = 1'b0;
        end
        dev_d_low = 1'b0;
        repeat (H) tick();
    endtask

    task automatic run_cmd(input logic [7:0] c);
        int used = 0, exp_done = 0, exp_err = 0, k = 0, d0, e0, i0;
        logic [7:0] r = resp_exp;
        for (int a = 0; a <= RET; a++) begin
            used++;
            if (plan_k[a] != K_OK) begin exp_err = 1; break; end
            r = plan_b[a];
            if (plan_b[a] != 8'hFE) begin exp_done = 1; break; end
            if (a == RET) begin exp_err = 1; break; end
        end
        while (!cmd_ready && k < 100) begin tick(); k++; end
        d0 = done_n; e0 = err_n; i0 = inh_runs;
        cmd = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("accept_latency", {busy, ps2c_oe}, 2'b11);
        resp_exp = r;
        for (int a = 0; a < used; a++) serve(c, plan_k[a], plan_b[a]);
        k = 0;
        while (done_n + err_n == d0 + e0 && k < int'(TMO) + 200) begin tick(); k++; end
        if (plan_k[used-1] == K_SILENT)
            check("timeout_window", (k >= int'(TMO) && k <= int'(TMO) + 4), 1);
        repeat (2) tick();
        check("done_count", done_n - d0, exp_done);
        check("err_count", err_n - e0, exp_err);
        check("attempts", inh_runs - i0, used);
        check("ready_after", cmd_ready, 1);
        check("resp", resp, r);
    endtask

    task automatic set_plan(input int k0, input logic [7:0] b0, input int k1,
                            input logic [7:0] b1, input int k2, input logic [7:0] b2);
        plan_k[0] = k0; plan_b[0] = b0;
        plan_k[1] = k1; plan_b[1] = b1;
        plan_k[2] = k2; plan_b[2] = b2;
    endtask

    initial begin
        bit ok;
        int d0, e0, rr;
        logic [7:0] c6 = 8'hA5;
        logic [7:0] rc;
        repeat (4) tick();
        reset = 1'b1;
        repeat (2) tick();
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_resp", resp, 8'h00);
        check("rst_pulses", {done, err}, 0);

        set_plan(K_OK, 8'hFA, K_OK, 8'h00, K_OK, 8'h00);
        run_cmd(8'hED);
        check("t1_frame_literal", last_fr, 10'h3ED);
        check("t1_resp_literal", resp, 8'hFA);

        set_plan(K_OK, 8'hFE, K_OK, 8'hFE, K_OK, 8'hFA);
        run_cmd(8'hFF);
        check("t2_frame_literal", last_fr, 10'h3FF);
        check("t2_resp_literal", resp, 8'hFA);

        set_plan(K_OK, 8'hFE, K_OK, 8'hFE, K_OK, 8'hFE);
        run_cmd(8'hF4);
        check("t3_resp_literal", resp, 8'hFE);

        set_plan(K_SILENT, 8'h00, K_OK, 8'h00, K_OK, 8'h00);
        run_cmd(8'hF2);

        set_plan(K_NACK, 8'h00, K_OK, 8'h00, K_OK, 8'h00);
        run_cmd(8'hED);
        set_plan(K_BADPAR, 8'hAA, K_OK, 8'h00, K_OK, 8'h00);
        run_cmd(8'h03);
        set_plan(K_OK, 8'hFE, K_BADPAR, 8'h12, K_OK, 8'h00);
        run_cmd(8'h55);

        // Reset in the low phase after the fifth falling clock of the host frame.
        cmd = c6;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_start(ok);
        repeat (12) tick();
        for (int i = 0; i < 4; i++) clk_pulse();
        dev_c_low = 1'b1;
        repeat (12) tick();
        check("t6_bit4", ps2d_oe, !c6[4]);
        d0 = done_n; e0 = err_n;
        reset = 1'b0;
        resp_exp = 8'h00;
        #1;
        check("t6_oe", {ps2c_oe, ps2d_oe}, 0);
        check("t6_ready", cmd_ready, 1);
        check("t6_busy", busy, 0);
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        inh_run = 0;
        inh_dlow = 0;
        repeat (5) tick();
        reset = 1'b1;
        repeat (20) tick();
        check("t6_no_pulse", (done_n - d0) + (err_n - e0), 0);
        set_plan(K_OK, 8'hFA, K_OK, 8'h00, K_OK, 8'h00);
        run_cmd(8'hED);

        for (int n = 0; n < 15; n++) begin
            for (int a = 0; a < 3; a++) begin
                rr = $urandom_range(0, 9);
                rc = 8'($urandom);
                if (rc == 8'hFE) rc = 8'hFA;
                plan_k[a] = (rr == 0) ? K_NACK : (rr == 1) ? K_BADPAR : K_OK;
                plan_b[a] = (rr >= 2 && rr <= 4) ? 8'hFE : rc;
            end
            run_cmd(8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
